// File: rtl/imem_loader.sv
// Byte-stream to IMEM word loader: packs little-endian bytes into IMEM_W-bit words
// and writes them to consecutive addresses from 0 while holding the core in reset.
module imem_loader #(
    parameter int IMEM_ADDR_W = 5,
    parameter int IMEM_W      = 32,
    parameter int DEPTH       = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [IMEM_ADDR_W:0]   len,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   we,
    output logic [IMEM_ADDR_W-1:0] waddr,
    output logic [IMEM_W-1:0]      wdata,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             dbg_state
);

    // Handshake: a byte moves on a rising edge when byte_valid && byte_ready;
    // byte_ready is registered and only ever high in RECV.

    localparam int BPW    = IMEM_W / 8;
    localparam int BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [BCNT_W-1:0]     r_bcnt;
    logic [IMEM_ADDR_W:0]  r_len;

    logic                  w_xfer;
    logic                  w_last;
    logic                  w_len_ok;
    logic [IMEM_ADDR_W:0]  w_waddr_inc;

    assign w_xfer      = byte_valid && byte_ready;
    assign w_last      = (r_bcnt == BCNT_W'(BPW - 1));
    assign w_len_ok    = (len != '0) && (int'(len) <= DEPTH);
    assign w_waddr_inc = {1'b0, waddr} + 1'b1;
    assign dbg_state   = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bcnt     <= '0;
            r_len      <= '0;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        r_len  <= len;
                        waddr  <= '0;
                        r_bcnt <= '0;
                        if (w_len_ok) begin
                            r_state    <= S_RECV;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            cpu_hold   <= 1'b1;
                            done       <= 1'b0;
                            err        <= 1'b0;
                        end else begin
                            r_state    <= S_DONE;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            cpu_hold   <= 1'b0;
                            done       <= 1'b1;
                            err        <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (abort) begin
                        // Abort beats a coinciding last byte, so no write is issued.
                        r_state    <= S_IDLE;
                        r_bcnt     <= '0;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        cpu_hold   <= 1'b0;
                        done       <= 1'b0;
                        err        <= 1'b0;
                    end else if (w_xfer) begin
                        for (int i = 0; i < BPW; i++) begin
                            if (r_bcnt == BCNT_W'(i)) begin
                                wdata[8*i +: 8] <= byte_data;
                            end
                        end
                        if (w_last) begin
                            r_state    <= S_WRITE;
                            r_bcnt     <= '0;
                            byte_ready <= 1'b0;
                            we         <= 1'b1;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        cpu_hold   <= 1'b0;
                        done       <= 1'b0;
                        err        <= 1'b0;
                    end else if (w_waddr_inc == r_len) begin
                        // waddr stays on the last written entry so it never passes DEPTH-1.
                        r_state  <= S_DONE;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        r_state    <= S_RECV;
                        waddr      <= waddr + 1'b1;
                        byte_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a byte-stream model predicts every IMEM write.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 10;
  localparam int BPW   = DW / 8;
  localparam int EW    = AW + DW;

  typedef logic [7:0] byte_q_t[$];

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   len = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    dbg_state;

  imem_loader #(.IMEM_ADDR_W(AW), .IMEM_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int we_cyc[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (byte_ready) ready_cnt++;
    if (we) begin
      we_cyc.push_back(cyc);
      check("we_cpu_hold", cpu_hold, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_we", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("we_waddr", waddr, mon_e[EW-1:DW]);
        check("we_wdata", wdata, mon_e[DW-1:0]);
      end
    end
  end

  // reference model: word k is bytes 4k..4k+3, little-endian, at address k
  task automatic model_load(input int n_words, input byte_q_t b);
    for (int w = 0; w < n_words; w++) begin
      if (b.size() >= (w + 1) * BPW) begin
        longint word = 0;
        for (int k = 0; k < BPW; k++) word += longint'(b[w*BPW + k]) << (8 * k);
        exp_q.push_back({AW'(w), DW'(word)});
      end
    end
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    return q;
  endfunction

  // driver tasks
  task automatic do_start(input int l);
    @(negedge clk);
    start = 1'b1;
    len   = (AW+1)'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic send_bytes(input byte_q_t b, input int gap_pct);
    int idx = 0;
    int budget = 4000;
    bit hs;
    while (idx < b.size() && budget > 0) begin
      @(negedge clk);
      budget--;
      if (int'($urandom_range(99)) < gap_pct) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom_range(255));
      end else begin
        byte_valid = 1'b1;
        byte_data  = b[idx];
      end
      hs = byte_valid && byte_ready;
      @(posedge clk);
      if (hs) idx++;
    end
    #1 byte_valid = 1'b0;
    if (idx < b.size()) check("send_timeout", idx, b.size());
  endtask

  task automatic wait_done(input string tag);
    int budget = 300;
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, done, 1);
  endtask

  task automatic load_random(input int l, input int gap_pct);
    byte_q_t b;
    int n0;
    b = rand_bytes(l * BPW);
    model_load(l, b);
    n0 = we_cyc.size();
    do_start(l);
    send_bytes(b, gap_pct);
    wait_done("rand_done");
    check("rand_we_count", we_cyc.size() - n0, l);
    check("rand_err", err, 0);
    check("rand_waddr_hold", waddr, l - 1);
  endtask

  initial begin
    byte_q_t b;
    int ls[3];

    // reset state
    repeat (3) @(negedge clk);
    check("rst_we", we, 0);
    check("rst_ready", byte_ready, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_flags", {cpu_hold, busy, done, err}, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    // single word, fixed bytes, latency
    b = {8'h93, 8'h01, 8'hF0, 8'h00};
    model_load(1, b);
    do_start(1);
    check("t1_busy", busy, 1);
    check("t1_hold", cpu_hold, 1);
    send_bytes(b, 0);
    @(negedge clk);
    check("t1_we_latency", we, 1);
    check("t1_waddr", waddr, 0);
    check("t1_wdata", wdata, 32'h00F00193);
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_we_off", we, 0);
    check("t1_idle_flags", {cpu_hold, busy, err, byte_ready}, 0);

    // full depth, back-to-back
    we_cyc.delete();
    b = rand_bytes(DEPTH * BPW);
    model_load(DEPTH, b);
    do_start(DEPTH);
    send_bytes(b, 0);
    wait_done("t2_done");
    check("t2_we_count", we_cyc.size(), DEPTH);
    for (int i = 1; i < we_cyc.size(); i++) check("t2_we_spacing", we_cyc[i] - we_cyc[i-1], BPW + 1);
    check("t2_waddr_hold", waddr, DEPTH - 1);
    check("t2_hold_released", cpu_hold, 0);

    // illegal lengths
    ls = '{0, DEPTH + 1, 63};
    foreach (ls[j]) begin
      ready_cnt = 0;
      we_cyc.delete();
      do_start(ls[j]);
      check("t3_err", err, 1);
      check("t3_done", done, 1);
      check("t3_busy_hold", {busy, cpu_hold}, 0);
      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      repeat (6) @(negedge clk);
      byte_valid = 1'b0;
      check("t3_ready_never", ready_cnt, 0);
      check("t3_no_we", we_cyc.size(), 0);
    end

    // random byte_valid gaps, then random lengths
    load_random(2, 50);
    for (int i = 0; i < 4; i++) load_random(int'($urandom_range(DEPTH, 1)), int'($urandom_range(60)));

    // abort mid word 1
    we_cyc.delete();
    b = rand_bytes(BPW + 2);
    model_load(2, b);
    do_start(2);
    send_bytes(b, 20);
    do_abort();
    check("t5_state_idle", dbg_state, 0);
    check("t5_flags", {busy, cpu_hold, done, err, byte_ready}, 0);
    repeat (BPW + 2) @(negedge clk);
    check("t5_we_count", we_cyc.size(), 1);
    load_random(1, 30);

    // async reset mid-RECV
    b = rand_bytes(BPW + 2);
    model_load(3, b);
    do_start(3);
    send_bytes(b, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_outputs", {we, byte_ready, cpu_hold, busy, done, err}, 0);
    check("t6_rst_waddr", waddr, 0);
    check("t6_rst_wdata", wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_random(1, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
